mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback select for the forwarding pipeline.
- Captures memory-stage results on the rising edge and formats load data (byte/half extract, sign/zero extend). Selects the writeback value.
- Drives the register file write port (rd_addr, rd_data, rd_wren) and the WB-stage forwarding source.
- Keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- PC_INC, 4, increment added to i_pc for the link (PC+4) writeback.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_stall  in  1  hold all stage registers.
- i_flush  in  1  insert a bubble into the stage.
- i_valid  in  1  MEM stage holds a real instruction.
- i_pc  in  32  PC of the MEM-stage instruction.
- i_alu_data  in  32  ALU result; bits [1:0] are the load byte offset.
- i_ld_raw  in  32  word-aligned read data from the LSU.
- i_ld_type  in  3  load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- i_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+PC_INC, 11 zero.
- i_rd_addr  in  5  destination register.
- i_rd_wren  in  1  instruction writes rd.
- o_rd_addr  out  5  to register file / forwarding unit.
- o_rd_data  out  32  writeback data.
- o_rd_wren  out  1  qualified write enable.
- o_valid  out  1  WB stage holds a valid instruction.
- o_pc  out  32  PC of the WB instruction (debug/trace).
- o_retire_cnt  out  32  count of instructions captured into WB.

Behaviour:
- Reset (async, i_reset=1): every output and internal register is 0 immediately, independent of the clock. Capture resumes on the first rising edge after deassertion.
- Priority at each rising edge: flush > stall > normal capture.
  - Flush: o_valid=0, o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_pc=0. Counter unchanged.
  - Stall (no flush): all registers, including the counter, hold their values.
  - Normal: register all fields. Latency is exactly 1 cycle from MEM inputs to WB outputs.
- Load formatting is combinational before the register, using off = i_alu_data[1:0]:
  - lb/lbu: byte i_ld_raw[8*off+7 : 8*off]; sign-extend for lb, zero-extend for lbu.
  - lh/lhu: half selected by off[1] (off[0] ignored, no misalign trap); sign- or zero-extend.
  - lw and the undefined codes 011/110/111: full i_ld_raw, off ignored.
- Writeback select: 00 gives i_alu_data; 01 gives formatted load; 10 gives i_pc+PC_INC, modulo 2^32 (0xFFFFFFFC+4 → 0); 11 gives 0.
- Write qualification: o_rd_wren = registered (i_valid & i_rd_wren & (i_rd_addr != 0)). A write to x0 never asserts wren.
- When i_valid=0 at a normal capture:
  - o_valid=0 and o_rd_wren=0.
  - o_rd_addr, o_rd_data and o_pc are still captured; they are don't-care.
- Retire counter: +1 on a normal capture with i_valid=1. Wraps 0xFFFFFFFF → 0.
- Register file writes on the falling edge, so o_rd_* must be stable from the rising edge through the next falling edge. All outputs come directly from flops; there are no combinational paths from inputs to outputs.
- Reset asserted mid-stall or mid-flush: reset wins immediately. No stale wren survives.

Test Plan:
1. Reset: assert i_reset asynchronously between edges → all outputs 0 before the next edge. Release → first valid capture gives o_retire_cnt=1.
2. Loads, with i_ld_raw=0x80F0_7F81, wb_sel=01, rd=5, valid, wren:
   - lb off=0 → 0xFFFFFF81
   - lbu off=1 → 0x0000007F
   - lh off=2 → 0xFFFF80F0
   - lhu off=3 → 0x000080F0
   - lw off=2 → 0x80F07F81
   - each with o_rd_wren=1 one cycle later.
3. Select: wb_sel=10, i_pc=0x0000_0100 → o_rd_data=0x104. i_pc=0xFFFF_FFFC → 0. wb_sel=11 → 0. wb_sel=00, alu=0x1234_5678 → 0x12345678.
4. x0 / invalid: rd=0 with wren=1, valid=1 → o_rd_wren=0, o_valid=1, counter +1. Then valid=0, rd=7, wren=1 → o_rd_wren=0, counter unchanged.
5. Stall/flush: capture rd=3, data=0xA5 → hold i_stall 3 cycles while inputs change → outputs and counter frozen. Then stall=1 and flush=1 together → bubble (o_valid=0, wren=0), counter unchanged.
6. Counter wrap: 2^32+2 valid captures, or a force of the counter to 0xFFFFFFFE followed by 3 valid captures → 0xFFFFFFFF, 0, 1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load formatting, writeback select and retire counter.
// Every output is driven straight from a flop, so o_rd_* holds steady from one rising edge to the next.
module mem_wb_stage #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_valid,
  input  logic [31:0]     i_pc,
  input  logic [31:0]     i_alu_data,
  input  logic [31:0]     i_ld_raw,
  input  logic [2:0]      i_ld_type,
  input  logic [1:0]      i_wb_sel,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_wren,
  output logic [4:0]      o_rd_addr,
  output logic [31:0]     o_rd_data,
  output logic            o_rd_wren,
  output logic            o_valid,
  output logic [31:0]     o_pc,
  output logic [31:0]     o_retire_cnt
);

  localparam logic [XLEN-1:0] PC_INC_V = XLEN'(PC_INC);

  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic [31:0] wb_data;

  logic        valid_d, valid_q;
  logic        wren_d, wren_q;
  logic [4:0]  rd_addr_d, rd_addr_q;
  logic [31:0] rd_data_d, rd_data_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] retire_cnt_d, retire_cnt_q;

  always_comb begin
    off = i_alu_data[1:0];
    case (off)
      2'd0:    ld_byte = i_ld_raw[7:0];
      2'd1:    ld_byte = i_ld_raw[15:8];
      2'd2:    ld_byte = i_ld_raw[23:16];
      default: ld_byte = i_ld_raw[31:24];
    endcase
    // off[0] is ignored for halves: misaligned halfwords are not trapped here
    ld_half = off[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];

    case (i_ld_type)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = i_ld_raw;
    endcase

    case (i_wb_sel)
      2'b00:   wb_data = i_alu_data;
      2'b01:   wb_data = ld_fmt;
      2'b10:   wb_data = i_pc + PC_INC_V;
      default: wb_data = '0;
    endcase
  end

  always_comb begin
    valid_d      = valid_q;
    wren_d       = wren_q;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    pc_d         = pc_q;
    retire_cnt_d = retire_cnt_q;

    if (i_flush) begin
      valid_d   = 1'b0;
      wren_d    = 1'b0;
      rd_addr_d = '0;
      rd_data_d = '0;
      pc_d      = '0;
    end else if (!i_stall) begin
      valid_d      = i_valid;
      wren_d       = i_valid & i_rd_wren & (i_rd_addr != 5'd0);
      rd_addr_d    = i_rd_addr;
      rd_data_d    = wb_data;
      pc_d         = i_pc;
      retire_cnt_d = retire_cnt_q + {31'd0, i_valid};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q      <= 1'b0;
      wren_q       <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      pc_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      wren_q       <= wren_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      pc_q         <= pc_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_rd_wren    = wren_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_rd_data    = rd_data_q;
  assign o_pc         = pc_q;
  assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed cases from the test plan plus a randomized run.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [31:0] pc = '0, alu = '0, raw = '0;
  logic [2:0]  ldt = '0;
  logic [1:0]  sel = '0;
  logic [4:0]  rd = '0;
  logic        wren = 1'b0;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data, o_pc, o_cnt;
  logic        o_rd_wren, o_valid;

  int tests = 0;
  int fails = 0;

  mem_wb_stage #(.XLEN(32), .PC_INC(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_pc(pc), .i_alu_data(alu), .i_ld_raw(raw), .i_ld_type(ldt), .i_wb_sel(sel),
    .i_rd_addr(rd), .i_rd_wren(wren),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren),
    .o_valid(o_valid), .o_pc(o_pc), .o_retire_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        known;
  } wb_t;

  wb_t m;
  wb_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] r, input logic [31:0] a, input logic [2:0] t);
    int unsigned o;
    logic [31:0] b, h;
    o = a % 4;
    b = (r >> (8 * o)) & 32'hFF;
    h = (o >= 2) ? (r >> 16) : (r & 32'hFFFF);
    case (t)
      3'd0: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] wb_val();
    case (sel)
      2'd0: return alu;
      2'd1: return load_val(raw, alu, ldt);
      2'd2: return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m = '{v:0, we:0, addr:0, data:0, pc:0, cnt:0, known:1};
  endtask

  // Inputs are already set; advance the model, clock once, queue the expectation.
  task automatic cycle();
    if (flush) begin
      m.v = 0; m.we = 0; m.addr = 0; m.data = 0; m.pc = 0; m.known = 1;
    end else if (!stall) begin
      m.v = valid;
      m.we = valid && wren && (rd != 0);
      m.addr = rd;
      m.data = wb_val();
      m.pc = pc;
      m.known = valid;
      if (valid) m.cnt = m.cnt + 1;
    end
    @(posedge clk);
    q.push_back(m);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] a, input logic [31:0] r,
                       input logic [2:0] t, input logic [1:0] s, input logic [4:0] d, input logic w,
                       input logic st, input logic fl);
    valid = v; pc = p; alu = a; raw = r; ldt = t; sel = s; rd = d; wren = w; stall = st; flush = fl;
    cycle();
  endtask

  always @(negedge clk) begin
    wb_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("valid", {31'd0, o_valid}, {31'd0, e.v});
      chk("rd_wren", {31'd0, o_rd_wren}, {31'd0, e.we});
      chk("retire_cnt", o_cnt, e.cnt);
      if (e.known) begin
        chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, e.addr});
        chk("rd_data", o_rd_data, e.data);
        chk("pc", o_pc, e.pc);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Activity, then async reset between edges
    drive(1, 32'h40, 32'h11, 0, 3'd2, 2'd0, 5'd9, 1, 0, 0);
    drive(1, 32'h44, 32'h22, 0, 3'd2, 2'd0, 5'd9, 1, 0, 0);
    drain();
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("rst_addr", {27'd0, o_rd_addr}, 32'd0);
    chk("rst_data", o_rd_data, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_cnt", o_cnt, 32'd0);
    model_reset();
    #1 rst = 1'b0;
    drive(1, 32'h80, 32'h5, 0, 3'd2, 2'd0, 5'd1, 1, 0, 0);

    // Load formatting
    drive(1, 32'h100, 32'h0, 32'h80F0_7F81, 3'b000, 2'b01, 5'd5, 1, 0, 0);
    drive(1, 32'h104, 32'h1, 32'h80F0_7F81, 3'b100, 2'b01, 5'd5, 1, 0, 0);
    drive(1, 32'h108, 32'h2, 32'h80F0_7F81, 3'b001, 2'b01, 5'd5, 1, 0, 0);
    drive(1, 32'h10C, 32'h3, 32'h80F0_7F81, 3'b101, 2'b01, 5'd5, 1, 0, 0);
    drive(1, 32'h110, 32'h2, 32'h80F0_7F81, 3'b010, 2'b01, 5'd5, 1, 0, 0);

    // Writeback select
    drive(1, 32'h0000_0100, 32'h0, 0, 3'd2, 2'b10, 5'd6, 1, 0, 0);
    drive(1, 32'hFFFF_FFFC, 32'h0, 0, 3'd2, 2'b10, 5'd6, 1, 0, 0);
    drive(1, 32'h200, 32'hDEAD_BEEF, 0, 3'd2, 2'b11, 5'd6, 1, 0, 0);
    drive(1, 32'h204, 32'h1234_5678, 0, 3'd2, 2'b00, 5'd6, 1, 0, 0);

    // x0 and invalid
    drive(1, 32'h208, 32'h77, 0, 3'd2, 2'b00, 5'd0, 1, 0, 0);
    drive(0, 32'h20C, 32'h88, 0, 3'd2, 2'b00, 5'd7, 1, 0, 0);

    // Stall holds, then stall+flush bubbles
    drive(1, 32'h300, 32'hA5, 0, 3'd2, 2'b00, 5'd3, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom), 5'($urandom), 1, 1, 0);
    drive(1, 32'h304, 32'h5A, 0, 3'd2, 2'b00, 5'd4, 1, 1, 1);

    // Counter wrap
    drain();
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.retire_cnt_q;
    m.cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++)
      drive(1, 32'h400 + 32'(4 * i), 32'h1, 0, 3'd2, 2'b00, 5'd2, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
